// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline register: width defaults,
// ctrl_ex bit positions and the payload bundle carried through the stage.
package id_ex_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_REG_W   = 5;

  localparam int unsigned REG_DST_BIT = 0;
  localparam int unsigned ALU_OP_LSB  = 1;
  localparam int unsigned ALU_SRC_BIT = 3;

  typedef struct packed {
    logic [DEF_REG_W-1:0]  rs_idx;
    logic [DEF_REG_W-1:0]  rt_idx;
    logic [DEF_REG_W-1:0]  rd_idx;
    logic [DEF_DATA_W-1:0] imm;
    logic [DEF_DATA_W-1:0] rs_data;
    logic [DEF_DATA_W-1:0] rt_data;
    logic [1:0]            ctrl_wb;
    logic [1:0]            ctrl_m;
    logic [3:0]            ctrl_ex;
  } id_ex_payload_t;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX stage bus: ID-side handshake and payload, EX-side handshake,
// registered payload, decoded EX control and bubble counter.
interface id_ex_pipe_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [REG_W-1:0]  rs_idx_i, rt_idx_i, rd_idx_i;
  logic [DATA_W-1:0] imm_i, rs_data_i, rt_data_i;
  logic [1:0]        ctrl_wb_i, ctrl_m_i;
  logic [3:0]        ctrl_ex_i;

  logic              out_valid_o;
  logic              out_ready_i;
  logic [REG_W-1:0]  rs_idx_o, rt_idx_o, rd_idx_o;
  logic [DATA_W-1:0] imm_o, rs_data_o, rt_data_o;
  logic [1:0]        ctrl_wb_o, ctrl_m_o;
  logic              reg_dst_o;
  logic [1:0]        alu_op_o;
  logic              alu_src_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport slave (
    input  in_valid_i, rs_idx_i, rt_idx_i, rd_idx_i, imm_i, rs_data_i,
           rt_data_i, ctrl_wb_i, ctrl_m_i, ctrl_ex_i, out_ready_i,
    output in_ready_o, out_valid_o, rs_idx_o, rt_idx_o, rd_idx_o, imm_o,
           rs_data_o, rt_data_o, ctrl_wb_o, ctrl_m_o, reg_dst_o, alu_op_o,
           alu_src_o, bubble_cnt_o
  );

  modport master (
    output in_valid_i, rs_idx_i, rt_idx_i, rd_idx_i, imm_i, rs_data_i,
           rt_data_i, ctrl_wb_i, ctrl_m_i, ctrl_ex_i, out_ready_i,
    input  in_ready_o, out_valid_o, rs_idx_o, rt_idx_o, rd_idx_o, imm_o,
           rs_data_o, rt_data_o, ctrl_wb_o, ctrl_m_o, reg_dst_o, alu_op_o,
           alu_src_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_skid_buf.sv
// Single-entry skid buffer for the ID/EX stage; ready_o is registered so the
// ID-side ready does not depend combinationally on the EX-side ready.
module id_ex_skid_buf
  import id_ex_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           flush_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  id_ex_payload_t data_i,
  output logic           valid_o,
  output logic           ready_o,
  output id_ex_payload_t data_o
);

  logic           valid_q, valid_d;
  logic           ready_q;
  id_ex_payload_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= !valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ready_o = ready_q;
  assign data_o  = data_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush, EX control
// decode and saturating bubble counter. Define ID_EX_SKID_EN for a skid entry.
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_W  = DEF_REG_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                flush_i,
  id_ex_pipe_reg_if.slave     bus
);

  id_ex_payload_t   in_pl, out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             out_free, accept;

  assign in_pl = '{
    rs_idx:  DEF_REG_W'(bus.rs_idx_i),
    rt_idx:  DEF_REG_W'(bus.rt_idx_i),
    rd_idx:  DEF_REG_W'(bus.rd_idx_i),
    imm:     DEF_DATA_W'(bus.imm_i),
    rs_data: DEF_DATA_W'(bus.rs_data_i),
    rt_data: DEF_DATA_W'(bus.rt_data_i),
    ctrl_wb: bus.ctrl_wb_i,
    ctrl_m:  bus.ctrl_m_i,
    ctrl_ex: bus.ctrl_ex_i
  };

  assign out_free = !out_valid_q || bus.out_ready_i;

`ifdef ID_EX_SKID_EN
  logic           skid_valid, skid_ready, skid_push, skid_pop;
  id_ex_payload_t skid_pl;

  // Skid ready is registered and equals "skid empty", so an accept can never
  // coincide with a pending skid entry; the output register always drains skid first.
  assign accept    = bus.in_valid_i && skid_ready;
  assign skid_push = accept && !out_free;
  assign skid_pop  = out_free && skid_valid;
  assign bus.in_ready_o = skid_ready;

  id_ex_skid_buf u_skid (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_i),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .data_i  (in_pl),
    .valid_o (skid_valid),
    .ready_o (skid_ready),
    .data_o  (skid_pl)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid_d = 1'b1;
        out_d       = skid_pl;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_d       = in_pl;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end
`else
  assign accept         = bus.in_valid_i && out_free;
  assign bus.in_ready_o = out_free;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_d       = in_pl;
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_comb begin
    bubble_d = bubble_q;
    if (!out_valid_q && bus.out_ready_i && bubble_q != '1) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      bubble_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      bubble_q    <= bubble_d;
    end
  end

  assign bus.out_valid_o  = out_valid_q;
  assign bus.rs_idx_o     = REG_W'(out_q.rs_idx);
  assign bus.rt_idx_o     = REG_W'(out_q.rt_idx);
  assign bus.rd_idx_o     = REG_W'(out_q.rd_idx);
  assign bus.imm_o        = DATA_W'(out_q.imm);
  assign bus.rs_data_o    = DATA_W'(out_q.rs_data);
  assign bus.rt_data_o    = DATA_W'(out_q.rt_data);
  assign bus.bubble_cnt_o = bubble_q;

  // Control leaving the stage is gated so an empty slot is a true no-op in EX.
  assign bus.ctrl_wb_o = out_valid_q ? out_q.ctrl_wb : '0;
  assign bus.ctrl_m_o  = out_valid_q ? out_q.ctrl_m  : '0;
  assign bus.reg_dst_o = out_valid_q && out_q.ctrl_ex[REG_DST_BIT];
  assign bus.alu_op_o  = out_valid_q ? out_q.ctrl_ex[ALU_OP_LSB +: 2] : '0;
  assign bus.alu_src_o = out_valid_q && out_q.ctrl_ex[ALU_SRC_BIT];

endmodule
